// File: rtl/arb_req_src.sv
// arb_req_src: two-port burst command source in front of a two-requester arbiter.
// Each port queues burst commands, requests the arbiter, plays one burst per grant
// onto a shared output bus, then drops its request until the grant is seen low.
module arb_req_src #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cmd_valid_i,
  output logic [1:0]    cmd_ready_o,
  input  logic [DW-1:0] cmd_data0_i,
  input  logic [DW-1:0] cmd_data1_i,
  input  logic [LW-1:0] cmd_len0_i,
  input  logic [LW-1:0] cmd_len1_i,
  output logic [1:0]    request_o,
  input  logic [1:0]    grant_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_port_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] BEAT_ONE = LW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BURST   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  logic [DW-1:0] cmd_data [2];
  logic [LW-1:0] cmd_len  [2];
  logic [DW-1:0] beat_data [2];
  logic [1:0]    beat_last;
  logic [1:0]    in_burst;
  logic          ready_en_q;
  logic          err_q;

  assign cmd_data[0] = cmd_data0_i;
  assign cmd_data[1] = cmd_data1_i;
  assign cmd_len[0]  = cmd_len0_i;
  assign cmd_len[1]  = cmd_len1_i;

  // Keep cmd_ready low while in reset; it opens on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // Sticky protocol error: the arbiter must never grant both ports together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         err_q <= 1'b0;
    else if (&grant_i)  err_q <= 1'b1;
  end

  assign err_o = err_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam int OI = 1 - gi;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [LW-1:0] beat_q, beat_d;
    logic [DW-1:0] mem_data [DEPTH];
    logic [LW-1:0] mem_len  [DEPTH];
    logic          full, empty, push, at_last;
    logic [DW-1:0] head_data;
    logic [LW-1:0] head_len;
    logic          port_req, port_burst, port_last, port_pop;
    logic [DW-1:0] port_data;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign cmd_ready_o[gi] = ready_en_q & ~full;
    assign push      = cmd_valid_i[gi] & cmd_ready_o[gi];
    assign head_data = mem_data[rd_ptr_q];
    assign head_len  = mem_len[rd_ptr_q];
    assign at_last   = (beat_q == head_len);

    // Command storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_data[wr_ptr_q] <= cmd_data[gi];
        mem_len[wr_ptr_q]  <= cmd_len[gi];
      end
    end

    // FIFO pointers and occupancy; a pop only happens on an accepted last beat.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push)     wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (port_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        case ({push, port_pop})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end

    // State and beat index registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        beat_q  <= '0;
      end else begin
        state_q <= state_d;
        beat_q  <= beat_d;
      end
    end

    // Next state: enter a burst only on an exclusive grant while the other port is idle on the bus.
    always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
        ST_IDLE: begin
          if (!empty) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (grant_i[gi] && !grant_i[OI] && !in_burst[OI]) begin
            state_d = ST_BURST;
            beat_d  = '0;
          end
        end
        ST_BURST: begin
          if (out_ready_i) begin
            if (at_last) state_d = ST_RELEASE;
            else         beat_d  = beat_q + BEAT_ONE;
          end
        end
        ST_RELEASE: begin
          if (!grant_i[gi]) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Per-port outputs: request held through REQ and BURST, beat payload only while bursting.
    always_comb begin
      port_req   = 1'b0;
      port_burst = 1'b0;
      port_last  = 1'b0;
      port_pop   = 1'b0;
      port_data  = '0;
      if (state_q == ST_REQ) port_req = 1'b1;
      if (state_q == ST_BURST) begin
        port_req   = 1'b1;
        port_burst = 1'b1;
        port_last  = at_last;
        port_data  = head_data + DW'(beat_q);
        port_pop   = out_ready_i & at_last;
      end
    end

    assign request_o[gi] = port_req;
    assign in_burst[gi]  = port_burst;
    assign beat_last[gi] = port_last;
    assign beat_data[gi] = port_data;
  end

  // Shared bus: at most one port bursts; everything reads zero when the bus is free.
  always_comb begin
    out_valid_o = |in_burst;
    out_port_o  = in_burst[1];
    out_data_o  = '0;
    out_last_o  = 1'b0;
    if (in_burst[0]) begin
      out_data_o = beat_data[0];
      out_last_o = beat_last[0];
    end else if (in_burst[1]) begin
      out_data_o = beat_data[1];
      out_last_o = beat_last[1];
    end
  end

endmodule

// File: tb/tb_arb_req_src.sv
// tb_arb_req_src: randomized and directed bench with a queue-based reference model
// and an emulated two-requester arbiter driving grant.
module tb_arb_req_src;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    cmd_valid = 2'b00;
  logic [1:0]    cmd_ready;
  logic [DW-1:0] cmd_data0 = '0, cmd_data1 = '0;
  logic [LW-1:0] cmd_len0 = '0, cmd_len1 = '0;
  logic [1:0]    request;
  logic [1:0]    grant = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_port;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          err;

  always #5 clk = ~clk;

  arb_req_src #(.DEPTH(DEPTH), .DW(DW), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_data0_i(cmd_data0), .cmd_data1_i(cmd_data1),
    .cmd_len0_i(cmd_len0), .cmd_len1_i(cmd_len1),
    .request_o(request), .grant_i(grant),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_port_o(out_port),
    .out_data_o(out_data), .out_last_o(out_last), .err_o(err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // All queued commands of both ports live in one list tagged by port; a port's
  // FIFO head is simply its oldest entry in that list.
  typedef struct packed {
    logic          port;
    logic [DW-1:0] d;
    logic [LW-1:0] l;
  } cmd_t;
  cmd_t mq[$];
  bit   m_wait[2];   // requesting, waiting for an exclusive grant
  bit   m_burst[2];  // playing beats
  bit   m_drain[2];  // burst done, waiting for grant to be seen low
  int   m_beat[2];
  bit   m_err;
  bit   m_rdy_en;

  function automatic int m_count(input int p);
    int n = 0;
    foreach (mq[i]) if (int'(mq[i].port) == p) n++;
    return n;
  endfunction

  function automatic int m_head(input int p);
    foreach (mq[i]) if (int'(mq[i].port) == p) return i;
    return -1;
  endfunction

  function automatic bit model_idle();
    return (mq.size() == 0) && !m_wait[0] && !m_wait[1] && !m_burst[0] && !m_burst[1]
           && !m_drain[0] && !m_drain[1];
  endfunction

  initial begin : model_proc
    int  cnt[2];
    bit  rdy[2];
    bit  was_b[2];
    int  h;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        for (int p = 0; p < 2; p++) begin
          m_wait[p] = 0; m_burst[p] = 0; m_drain[p] = 0; m_beat[p] = 0;
        end
        m_err = 0;
        m_rdy_en = 0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          cnt[p]   = m_count(p);
          rdy[p]   = m_rdy_en && (cnt[p] < DEPTH);
          was_b[p] = m_burst[p];
        end
        for (int p = 0; p < 2; p++) begin
          if (m_drain[p]) begin
            if (!grant[p]) m_drain[p] = 0;
          end else if (m_burst[p]) begin
            if (out_ready) begin
              h = m_head(p);
              if (m_beat[p] == int'(mq[h].l)) begin
                mq.delete(h);
                m_burst[p] = 0;
                m_drain[p] = 1;
              end else begin
                m_beat[p]++;
              end
            end
          end else if (m_wait[p]) begin
            if (grant[p] && !grant[1-p] && !was_b[1-p]) begin
              m_wait[p]  = 0;
              m_burst[p] = 1;
              m_beat[p]  = 0;
            end
          end else if (cnt[p] > 0) begin
            m_wait[p] = 1;
          end
        end
        if (cmd_valid[0] && rdy[0]) mq.push_back('{1'b0, cmd_data0, cmd_len0});
        if (cmd_valid[1] && rdy[1]) mq.push_back('{1'b1, cmd_data1, cmd_len1});
        if (grant == 2'b11) m_err = 1;
        m_rdy_en = 1;
      end
    end
  end

  task automatic check_all();
    logic [1:0]    e_rdy, e_req;
    logic          e_valid, e_port, e_last;
    logic [DW-1:0] e_data;
    int            h;
    e_valid = 0; e_port = 0; e_last = 0; e_data = '0;
    for (int p = 0; p < 2; p++) begin
      e_rdy[p] = m_rdy_en && (m_count(p) < DEPTH);
      e_req[p] = m_wait[p] || m_burst[p];
      if (m_burst[p]) begin
        h = m_head(p);
        e_valid = 1;
        e_port  = 1'(p);
        e_data  = DW'(int'(mq[h].d) + m_beat[p]);
        e_last  = (m_beat[p] == int'(mq[h].l));
      end
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
    chk("request",   32'(request),   32'(e_req));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_port",  32'(out_port),  32'(e_port));
    chk("out_data",  32'(out_data),  32'(e_data));
    chk("out_last",  32'(out_last),  32'(e_last));
    chk("err",       32'(err),       32'(m_err));
  endtask

  // Every-cycle comparison, sampled 2 time units after the active edge.
  initial begin : compare_proc
    forever begin
      @(posedge clk);
      #2;
      check_all();
    end
  end

  // ---------------- arbiter emulation and stimulus helpers ----------------
  int owner = -1;
  int last_owner = 1;
  bit arb_en = 0;
  bit force11 = 0;

  task automatic arb_step();
    int c;
    if (!reset) begin
      grant = 2'b00; owner = -1;
    end else if (force11) begin
      grant = 2'b11; owner = -1;
    end else if (!arb_en) begin
      grant = 2'b00; owner = -1;
    end else if (owner >= 0) begin
      if (!request[owner]) begin grant = 2'b00; owner = -1; end
    end else if (grant != 2'b00) begin
      grant = 2'b00;
    end else begin
      c = 1 - last_owner;
      if (!request[c]) c = last_owner;
      if (request[c] && ($urandom_range(0, 3) != 0)) begin
        grant = 2'b00; grant[c] = 1'b1; owner = c; last_owner = c;
      end
    end
  endtask

  typedef struct {
    int            port;
    logic [DW-1:0] d;
    logic          last;
  } beat_t;
  beat_t blog[$];

  // One clock: capture the beat that the coming edge will accept, then move to the
  // next falling edge and update the arbiter.
  task automatic tick();
    #1;
    if (reset && out_valid && out_ready) begin
      blog.push_back('{int'(out_port), out_data, out_last});
      if (out_last) $display("burst done: port %0d last beat %02h", out_port, out_data);
    end
    @(negedge clk);
    arb_step();
  endtask

  task automatic push(input int p, input logic [DW-1:0] d, input logic [LW-1:0] l);
    cmd_valid = 2'b00;
    cmd_valid[p] = 1'b1;
    if (p == 0) begin cmd_data0 = d; cmd_len0 = l; end
    else        begin cmd_data1 = d; cmd_len1 = l; end
    tick();
    cmd_valid = 2'b00;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (!(model_idle() && request == 2'b00 && !out_valid) && n < limit) begin
      tick();
      n++;
    end
    vectors++;
    if (!(model_idle() && request == 2'b00 && !out_valid)) begin
      miscompares++;
      $display("FAIL %s: not idle after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n = 0;
    while (!out_valid && n < limit) begin tick(); n++; end
    chk({name, " beat started"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_beats(input string name, input int port, input logic [DW-1:0] exp [4],
                             input int n);
    chk({name, " beat count"}, 32'(blog.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < blog.size()) begin
        chk({name, " data"}, 32'(blog[i].d), 32'(exp[i]));
        chk({name, " port"}, 32'(blog[i].port), 32'(port));
        chk({name, " last"}, 32'(blog[i].last), 32'(i == n - 1));
      end
    end
  endtask

  function automatic int count_lasts(input int port);
    int n = 0;
    foreach (blog[i]) if (blog[i].last && blog[i].port == port) n++;
    return n;
  endfunction

  // ---------------- directed and random sequence ----------------
  initial begin : main_proc
    logic [DW-1:0] exp_a [4];
    bit            pat [6];
    int            n;

    #1 reset = 1'b0;
    repeat (2) tick();
    chk("in reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("in reset request", 32'(request), 32'd0);
    chk("in reset out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    arb_en = 1;
    out_ready = 1'b1;
    tick();
    chk("ready after release", 32'(cmd_ready), 32'h3);

    // Single port0 burst, data 10, len 3.
    blog.delete();
    push(0, 8'h10, 4'd3);
    wait_idle("t1 drain", 60);
    exp_a = '{8'h10, 8'h11, 8'h12, 8'h13};
    check_beats("t1", 0, exp_a, 4);

    // Port1 burst with data wrap.
    blog.delete();
    push(1, 8'hFE, 4'd2);
    wait_idle("t2 drain", 60);
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h00};
    check_beats("t2", 1, exp_a, 3);

    // Fill port0 without grants, overflow push ignored.
    blog.delete();
    arb_en = 0;
    for (int i = 0; i < 4; i++) push(0, DW'(8'h20 + 16 * i), LW'(i));
    chk("t3 full ready0", 32'(cmd_ready[0]), 32'd0);
    push(0, 8'hEE, 4'd1);
    chk("t3 still full", 32'(cmd_ready[0]), 32'd0);
    arb_en = 1;
    n = 0;
    while (!cmd_ready[0] && n < 40) begin tick(); n++; end
    chk("t3 ready back", 32'(cmd_ready[0]), 32'd1);
    chk("t3 bursts before ready", 32'(count_lasts(0)), 32'd1);
    wait_idle("t3 drain", 120);
    chk("t3 total bursts", 32'(count_lasts(0)), 32'd4);
    chk("t3 total beats", 32'(blog.size()), 32'd10);

    // Both ports loaded, alternating arbiter, random backpressure.
    blog.delete();
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 2'b11;
      cmd_data0 = DW'($urandom); cmd_len0 = LW'($urandom_range(0, 4));
      cmd_data1 = DW'($urandom); cmd_len1 = LW'($urandom_range(0, 4));
      tick();
    end
    cmd_valid = 2'b00;
    for (int i = 0; i < 150; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t4 drain", 200);
    chk("t4 port0 bursts", 32'(count_lasts(0)), 32'd3);
    chk("t4 port1 bursts", 32'(count_lasts(1)), 32'd3);

    // Backpressure pattern 1,0,0,1 during a len 3 burst.
    blog.delete();
    push(0, 8'h40, 4'd3);
    wait_valid("t5", 40);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t5 drain", 40);
    exp_a = '{8'h40, 8'h41, 8'h42, 8'h43};
    check_beats("t5", 0, exp_a, 4);

    // Double grant with both ports requesting, then reset mid-burst.
    arb_en = 0;
    push(0, 8'h50, 4'd3);
    push(1, 8'h60, 4'd3);
    repeat (3) tick();
    chk("t6 both requesting", 32'(request), 32'h3);
    force11 = 1;
    repeat (3) tick();
    force11 = 0;
    tick();
    chk("t6 err set", 32'(err), 32'd1);
    chk("t6 no beats", 32'(out_valid), 32'd0);
    arb_en = 1;
    wait_valid("t6", 40);
    tick();
    chk("t6 err sticky", 32'(err), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6 reset out_valid", 32'(out_valid), 32'd0);
    chk("t6 reset out_data", 32'(out_data), 32'd0);
    chk("t6 reset out_last", 32'(out_last), 32'd0);
    chk("t6 reset request", 32'(request), 32'd0);
    chk("t6 reset err", 32'(err), 32'd0);
    chk("t6 reset cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 2'b11;
    repeat (2) tick();
    cmd_valid = 2'b00;
    reset = 1'b1;
    tick();
    chk("t6 ready after release", 32'(cmd_ready), 32'h3);
    tick();
    chk("t6 nothing queued", 32'(request), 32'd0);

    // Random traffic with occasional double grants.
    for (int i = 0; i < 2000; i++) begin
      cmd_valid[0] = ($urandom_range(0, 2) == 0);
      cmd_valid[1] = ($urandom_range(0, 2) == 0);
      cmd_data0 = DW'($urandom); cmd_len0 = LW'($urandom_range(0, 15));
      cmd_data1 = DW'($urandom); cmd_len1 = LW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      force11 = ($urandom_range(0, 63) == 0);
      tick();
    end
    cmd_valid = 2'b00;
    force11 = 0;
    out_ready = 1'b1;
    wait_idle("random drain", 800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
